// File: rtl/tt_serial_pkg.sv
// Shared types and constants for the teletype 8N1 serial port.
package tt_serial_pkg;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

  localparam logic [3:0] OS_LAST     = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] OS_MID_LAST = 4'(MID_SAMPLE - 1);
  localparam logic [2:0] BIT_LAST    = 3'(DATA_BITS - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/tt_serial_port_baud_tick.sv
// Baud enables: rx_tick every CLK_DIV clks, tx_tick on every 16th rx_tick.
module tt_baud_tick
  import tt_serial_pkg::*;
#(
  parameter int CLK_DIV = 325
) (
  input  logic clk,
  input  logic reset,
  output logic rx_tick,
  output logic tx_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       os_q, os_d;

  always_comb begin
    rx_tick = (div_q == DIV_LAST);
    tx_tick = rx_tick && (os_q == OS_LAST);
    div_d   = rx_tick ? '0 : div_q + 1'b1;
    os_d    = rx_tick ? os_q + 1'b1 : os_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      os_q  <= '0;
    end else begin
      div_q <= div_d;
      os_q  <= os_d;
    end
  end

endmodule

// File: rtl/tt_serial_port.sv
// 8N1 serial port with four-phase req/ack byte interfaces for the TTI/TTO device.
module tt_serial_port
  import tt_serial_pkg::*;
#(
  parameter int CLK_DIV = 325
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       tx_ack,
  output logic       tx_empty,
  input  logic       rx_req,
  output logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_empty,
  input  logic       rxd,
  output logic       txd,
  output tx_state_e  tx_state_dbg,
  output rx_state_e  rx_state_dbg
);

  logic rx_tick, tx_tick;

  tt_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk     (clk),
    .reset   (reset),
    .rx_tick (rx_tick),
    .tx_tick (tx_tick)
  );

  // Handshakes: a request is accepted when req=1 and ack=0; ack then holds
  // until req is sampled low, so each req/ack cycle moves exactly one byte.

  tx_state_e  tx_state_q, tx_state_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic       tx_go_q, tx_go_d;
  logic       txd_q, txd_d;
  logic       tx_ack_q, tx_ack_d;
  logic       tx_empty_q, tx_empty_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_go_d    = tx_go_q;
    txd_d      = txd_q;
    tx_ack_d   = tx_ack_q & tx_req;
    tx_empty_d = tx_empty_q;
    case (tx_state_q)
      TX_IDLE: if (tx_req && !tx_ack_q) begin
        tx_shift_d = tx_data;
        tx_ack_d   = 1'b1;
        tx_empty_d = 1'b0;
        tx_go_d    = 1'b0;
        tx_state_d = TX_START;
      end
      // First tick drives the start bit; the second ends it.
      TX_START: if (tx_tick) begin
        if (!tx_go_q) begin
          txd_d   = 1'b0;
          tx_go_d = 1'b1;
        end else begin
          txd_d      = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: if (tx_tick) begin
        if (tx_bit_q == BIT_LAST) begin
          txd_d      = 1'b1;
          tx_state_d = TX_STOP;
        end else begin
          txd_d      = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 1'b1;
        end
      end
      TX_STOP: if (tx_tick) begin
        tx_empty_d = 1'b1;
        tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_go_q    <= 1'b0;
      txd_q      <= 1'b1;
      tx_ack_q   <= 1'b0;
      tx_empty_q <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_go_q    <= tx_go_d;
      txd_q      <= txd_d;
      tx_ack_q   <= tx_ack_d;
      tx_empty_q <= tx_empty_d;
    end
  end

  logic rxd_meta_q, rxd_sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
    end
  end

  rx_state_e  rx_state_q, rx_state_d;
  logic [3:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_hold_q, rx_hold_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_empty_q, rx_empty_d;
  logic       rx_ack_q, rx_ack_d;
  logic       rx_byte_done;

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_hold_d    = rx_hold_q;
    rx_data_d    = rx_data_q;
    rx_empty_d   = rx_empty_q;
    rx_ack_d     = rx_ack_q & rx_req;
    rx_byte_done = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (rx_tick && !rxd_sync_q) begin
        rx_cnt_d   = '0;
        rx_state_d = RX_START;
      end
      RX_START: if (rx_tick) begin
        if (rx_cnt_q == OS_MID_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: if (rx_tick) begin
        if (rx_cnt_q == OS_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == BIT_LAST) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: if (rx_tick) begin
        if (rx_cnt_q == OS_LAST) begin
          rx_byte_done = rxd_sync_q;
          rx_state_d   = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase

    if (rx_req && !rx_ack_q && !rx_empty_q) begin
      rx_data_d  = rx_hold_q;
      rx_ack_d   = 1'b1;
      rx_empty_d = 1'b1;
    end
    // A completing byte lands after delivery so the holding register stays full.
    if (rx_byte_done) begin
      rx_hold_d  = rx_shift_q;
      rx_empty_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_hold_q  <= '0;
      rx_data_q  <= '0;
      rx_empty_q <= 1'b1;
      rx_ack_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_hold_q  <= rx_hold_d;
      rx_data_q  <= rx_data_d;
      rx_empty_q <= rx_empty_d;
      rx_ack_q   <= rx_ack_d;
    end
  end

  assign txd          = txd_q;
  assign tx_ack       = tx_ack_q;
  assign tx_empty     = tx_empty_q;
  assign rx_ack       = rx_ack_q;
  assign rx_data      = rx_data_q;
  assign rx_empty     = rx_empty_q;
  assign tx_state_dbg = tx_state_q;
  assign rx_state_dbg = rx_state_q;

endmodule

// File: tb/tb_tt_serial_port.sv
// Directed bench for tt_serial_port at CLK_DIV=1 (one bit = 16 clks).
module tb_tt_serial_port;
  import tt_serial_pkg::*;

  localparam int CLK_DIV  = 1;
  localparam int BIT_CLKS = 16 * CLK_DIV;

  logic       clk, reset;
  logic       tx_req, tx_ack, tx_empty, txd;
  logic [7:0] tx_data;
  logic       rx_req, rx_ack, rx_empty, rxd;
  logic [7:0] rx_data;
  tx_state_e  tx_state_dbg;
  rx_state_e  rx_state_dbg;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_rx_data = 8'h00;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       do_read;
    logic       exp_empty;
  } rx_vec_t;

  rx_vec_t    rx_vecs[6];
  logic [7:0] tx_vecs[4];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  tt_serial_port #(.CLK_DIV(CLK_DIV)) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_req       (tx_req),
    .tx_data      (tx_data),
    .tx_ack       (tx_ack),
    .tx_empty     (tx_empty),
    .rx_req       (rx_req),
    .rx_ack       (rx_ack),
    .rx_data      (rx_data),
    .rx_empty     (rx_empty),
    .rxd          (rxd),
    .txd          (txd),
    .tx_state_dbg (tx_state_dbg),
    .rx_state_dbg (rx_state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: send one byte over the TX handshake and verify the serial frame
  task automatic tx_send(input logic [7:0] data, input bit hold);
    logic [9:0] frame;
    int k, bad, empty_bad;
    frame   = {1'b1, data, 1'b0};
    tx_data = data;
    tx_req  = 1'b1;
    for (k = 0; k < 8; k++) begin
      @(negedge clk);
      if (tx_ack === 1'b1) break;
    end
    check("tx_ack_latency", k, 0);
    check("tx_empty_at_ack", tx_empty, 0);
    if (!hold) tx_req = 1'b0;
    for (k = 0; k < 40; k++) begin
      if (txd === 1'b0) break;
      @(negedge clk);
    end
    check("tx_start_seen", txd, 0);
    bad = 0;
    empty_bad = 0;
    for (int b = 0; b < 10; b++) begin
      for (int j = 0; j < BIT_CLKS; j++) begin
        if (txd !== frame[b]) bad++;
        if (tx_empty !== 1'b0) empty_bad++;
        @(negedge clk);
      end
    end
    check("tx_bits", bad, 0);
    check("tx_empty_busy", empty_bad, 0);
    check("tx_empty_done", tx_empty, 1);
    check("txd_idle_after", txd, 1);
    check("tx_ack_after_frame", tx_ack, hold);
  endtask

  // driver: put one frame on rxd, then idle long enough to settle
  task automatic rx_frame(input logic [7:0] data, input logic stop);
    logic [9:0] frame;
    frame = {stop, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rxd = frame[b];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    if (stop) begin
      exp_q.delete();
      exp_q.push_back(data);
    end
  endtask

  task automatic rx_read(input bit expect_ack);
    logic [7:0] e;
    rx_req = 1'b1;
    @(negedge clk);
    if (expect_ack) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check("rx_ack_rise", rx_ack, 1);
      check("rx_data", rx_data, e);
      check("rx_empty_after_read", rx_empty, 1);
      last_rx_data = e;
    end else begin
      check("rx_no_ack_when_empty", rx_ack, 0);
      check("rx_data_unchanged", rx_data, last_rx_data);
    end
    rx_req = 1'b0;
    @(negedge clk);
    check("rx_ack_drop", rx_ack, 0);
    check("rx_data_hold", rx_data, last_rx_data);
  endtask

  initial begin
    int bad;

    tx_vecs[0] = 8'h41;
    tx_vecs[1] = 8'hA5;
    tx_vecs[2] = 8'h00;
    tx_vecs[3] = 8'hFF;
    rx_vecs[0] = '{8'h5A, 1'b1, 1'b1, 1'b0};
    rx_vecs[1] = '{8'hC3, 1'b0, 1'b1, 1'b1};
    rx_vecs[2] = '{8'h11, 1'b1, 1'b0, 1'b0};
    rx_vecs[3] = '{8'h22, 1'b1, 1'b1, 1'b0};
    rx_vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    rx_vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b0};

    reset   = 1'b1;
    tx_req  = 1'b0;
    tx_data = 8'h00;
    rx_req  = 1'b0;
    rxd     = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_tx_empty", tx_empty, 1);
    check("rst_rx_empty", rx_empty, 1);
    check("rst_tx_ack", tx_ack, 0);
    check("rst_rx_ack", rx_ack, 0);
    check("rst_rx_data", rx_data, 8'h00);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // short low glitch must be rejected as a false start
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    check("rx_glitch_empty", rx_empty, 1);

    foreach (tx_vecs[i]) tx_send(tx_vecs[i], 1'b0);

    // back-pressure: req held through the frame yields only one frame
    tx_send(8'h3C, 1'b1);
    bad = 0;
    for (int j = 0; j < 40; j++) begin
      if (txd !== 1'b1 || tx_empty !== 1'b1 || tx_ack !== 1'b1) bad++;
      @(negedge clk);
    end
    check("tx_hold_single_frame", bad, 0);
    tx_req = 1'b0;
    @(negedge clk);
    check("tx_hold_ack_drop", tx_ack, 0);

    // reset in the middle of a frame aborts it
    tx_data = 8'h55;
    tx_req  = 1'b1;
    @(negedge clk);
    tx_req = 1'b0;
    repeat (40) @(negedge clk);
    check("tx_midframe_busy", tx_empty, 0);
    reset = 1'b1;
    @(negedge clk);
    check("tx_abort_txd", txd, 1);
    check("tx_abort_empty", tx_empty, 1);
    check("tx_abort_ack", tx_ack, 0);
    reset = 1'b0;
    bad = 0;
    for (int j = 0; j < 200; j++) begin
      if (txd !== 1'b1) bad++;
      @(negedge clk);
    end
    check("tx_abort_line_idle", bad, 0);

    foreach (rx_vecs[i]) begin
      rx_frame(rx_vecs[i].data, rx_vecs[i].stop);
      check("rx_empty_after_frame", rx_empty, rx_vecs[i].exp_empty);
      if (rx_vecs[i].do_read) rx_read(!rx_vecs[i].exp_empty);
    end
    check("rx_final_empty", rx_empty, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
